// File: rtl/knn_pkg.sv
// Shared definitions for the KNN memory responder: controller states and the
// word-address memory map (functions for any geometry, constants for the default one).
package knn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_DONE,
        STORE,
        STORE_DONE
    } knn_state_t;

    function automatic int type_base(input int m, input int n, input int l);
        return l * m * n;
    endfunction

    function automatic int input_base(input int m, input int n, input int l);
        return type_base(m, n, l) + l;
    endfunction

    function automatic int dist_base(input int m, input int n, input int l);
        return input_base(m, n, l) + m * n;
    endfunction

    function automatic int outtype_base(input int m, input int n, input int l);
        return dist_base(m, n, l) + l;
    endfunction

    function automatic int load_len(input int m, input int n, input int l);
        return l * m * n + l + m * n;
    endfunction

    // Memory map of the default geometry (M=4, N=4, L=8).
    localparam int TRAIN_BASE   = 0;
    localparam int TYPE_BASE    = type_base(4, 4, 8);
    localparam int INPUT_BASE   = input_base(4, 4, 8);
    localparam int DIST_BASE    = dist_base(4, 4, 8);
    localparam int OUTTYPE_BASE = outtype_base(4, 4, 8);
    localparam int T            = load_len(4, 4, 8);

endpackage

// File: rtl/knn_addr_seq.sv
// Loadable word counter: restarts at start, steps on advance, and flags the
// last word of a run of len words.
module knn_addr_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [CNT_W-1:0] start,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    // NOTE: state in clocked blocks uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= start;
        end else if (advance) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == start + len - CNT_W'(1));

endmodule

// File: rtl/knn_mem_responder.sv
// Memory-side responder for the KNN core: streams training set, labels and query
// out of a single-port RAM on read, writes sorted distances/types back on write.
module knn_mem_responder
    import knn_pkg::*;
#(
    parameter int M      = 4,
    parameter int N      = 4,
    parameter int W      = 16,
    parameter int L      = 8,
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read,
    output logic                 read_done,
    input  logic                 write,
    output logic                 write_done,
    output logic [L*M*N*W-1:0]   training_data,
    output logic [L*W-1:0]       training_data_type,
    output logic [M*N*W-1:0]     input_data,
    input  logic [L*W-1:0]       distance_array_sorted,
    input  logic [L*W-1:0]       type_array_sorted,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [W-1:0]         mem_wdata,
    input  logic [W-1:0]         mem_rdata
);

    localparam int LMN         = L * M * N;
    localparam int MN          = M * N;
    localparam int A_TYPE      = type_base(M, N, L);
    localparam int A_INPUT     = input_base(M, N, L);
    localparam int A_DIST      = dist_base(M, N, L);
    localparam int LOAD_WORDS  = load_len(M, N, L);
    localparam int STORE_WORDS = 2 * L;
    localparam int CNT_W       = $clog2(LOAD_WORDS + 1);

    knn_state_t       state, state_next;
    logic             drain, drain_next;
    logic             read_done_next, write_done_next;
    logic             issuing;
    logic             ld_load, ld_adv, ld_last;
    logic             st_load, st_adv, st_last;
    logic [CNT_W-1:0] ld_count, st_count;
    logic             cap_valid;
    logic [CNT_W-1:0] cap_idx;
    logic [W-1:0]     store_word;
    logic [LOAD_WORDS-1:0] word_en;

    knn_addr_seq #(.CNT_W(CNT_W)) u_load_seq (
        .clk     (clk),
        .rst     (rst),
        .load    (ld_load),
        .advance (ld_adv),
        .start   ('0),
        .len     (CNT_W'(LOAD_WORDS)),
        .count   (ld_count),
        .last    (ld_last)
    );

    knn_addr_seq #(.CNT_W(CNT_W)) u_store_seq (
        .clk     (clk),
        .rst     (rst),
        .load    (st_load),
        .advance (st_adv),
        .start   ('0),
        .len     (CNT_W'(STORE_WORDS)),
        .count   (st_count),
        .last    (st_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            drain      <= 1'b0;
            read_done  <= 1'b0;
            write_done <= 1'b0;
            cap_valid  <= 1'b0;
            cap_idx    <= '0;
        end else begin
            state      <= state_next;
            drain      <= drain_next;
            read_done  <= read_done_next;
            write_done <= write_done_next;
            cap_valid  <= issuing;
            cap_idx    <= ld_count;
        end
    end

    // Distances occupy store words 0..L-1 and types L..2L-1, so one counter covers both.
    always_comb begin
        store_word = '0;
        for (int l = 0; l < L; l++) begin
            if (st_count == CNT_W'(l))     store_word = distance_array_sorted[l*W +: W];
            if (st_count == CNT_W'(L + l)) store_word = type_array_sorted[l*W +: W];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_next      = state;
        drain_next      = drain;
        read_done_next  = read_done;
        write_done_next = write_done;
        issuing         = 1'b0;
        ld_load         = 1'b0;
        ld_adv          = 1'b0;
        st_load         = 1'b0;
        st_adv          = 1'b0;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        case (state)
            IDLE: begin
                if (read) begin
                    state_next = LOAD;
                    drain_next = 1'b0;
                    ld_load    = 1'b1;
                end else if (write) begin
                    state_next = STORE;
                    st_load    = 1'b1;
                end
            end
            LOAD: begin
                if (drain) begin
                    drain_next = 1'b0;
                    state_next = LOAD_DONE;
                end else begin
                    issuing  = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = ADDR_W'(int'(ld_count));
                    ld_adv   = !ld_last;
                    if (ld_last) drain_next = 1'b1;
                end
            end
            // Done is raised one cycle after entry so a request already dropped still sees a 1-cycle pulse.
            LOAD_DONE: begin
                if (!read_done) begin
                    read_done_next = 1'b1;
                end else if (!read) begin
                    read_done_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            STORE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'(A_DIST + int'(st_count));
                mem_wdata = store_word;
                st_adv    = !st_last;
                if (st_last) state_next = STORE_DONE;
            end
            STORE_DONE: begin
                if (!write_done) begin
                    write_done_next = 1'b1;
                end else if (!write) begin
                    write_done_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // RAM data for the word issued last cycle is on mem_rdata now; one-hot decode by capture index.
    always_comb begin
        word_en = '0;
        for (int i = 0; i < LOAD_WORDS; i++) begin
            word_en[i] = cap_valid && (cap_idx == CNT_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            training_data      <= '0;
            training_data_type <= '0;
            input_data         <= '0;
        end else begin
            for (int i = 0; i < LMN; i++) begin
                if (word_en[i]) training_data[i*W +: W] <= mem_rdata;
            end
            for (int l = 0; l < L; l++) begin
                if (word_en[A_TYPE + l]) training_data_type[l*W +: W] <= mem_rdata;
            end
            for (int j = 0; j < MN; j++) begin
                if (word_en[A_INPUT + j]) input_data[j*W +: W] <= mem_rdata;
            end
        end
    end

endmodule
